// File: rtl/boot_dma.sv
// -----------------------------------------------------------------------------
// boot_dma
//
// Single-channel bus-master copy engine. It moves a block of bytes, halfwords
// or words from one data_bus address range to another, for example a flash
// image into RAM at boot. A clock-enable prescaler paces the bus: one bus step
// (one read or one write) completes every DIV+1 clk cycles. Each transfer is a
// read step followed by a write step. With AUTO_BOOT set, the preset BOOT_*
// copy starts straight out of reset.
//
// BOOT_SRC / BOOT_DST default to the flash and RAM base addresses of the
// reference SoC. Override them when integrating into another memory map.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   start         in   single-cycle request, cfg_* latched when not busy
//   cfg_src       in   source start address
//   cfg_dst       in   destination start address
//   cfg_count     in   number of transfers
//   cfg_len       in   access size: 00 byte, 01 half, 10 word, 11 illegal
//   busy          out  copy in progress (READ or WRITE)
//   done          out  last copy completed, sticky until next start
//   error         out  last copy aborted, sticky until next start
//   xfer_cnt      out  transfers completed in current or last copy
//   bus_rw        out  0 read, 1 write
//   bus_len       out  access size (latched len)
//   bus_addr      out  source address (read) or destination address (write)
//   bus_wdata     out  data held from the previous read
//   bus_rdata     in   combinational read data from data_bus
//   bus_exception in   data_bus access fault for the current address
// -----------------------------------------------------------------------------
module boot_dma #(
    parameter int          DIV        = 0,
    parameter int          DIV_W      = 20,
    parameter int          CNT_W      = 16,
    parameter bit          AUTO_BOOT  = 1'b1,
    parameter logic [31:0] BOOT_SRC   = 32'h0000_0000,
    parameter logic [31:0] BOOT_DST   = 32'h2000_0000,
    parameter int          BOOT_COUNT = 261
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      cfg_src,
    input  logic [31:0]      cfg_dst,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [1:0]       cfg_len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             bus_rw,
    output logic [1:0]       bus_len,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wdata,
    input  logic [31:0]      bus_rdata,
    input  logic             bus_exception
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [DIV_W-1:0] DIV_V     = DIV_W'(DIV);
    localparam logic [CNT_W-1:0] BOOT_CNT  = CNT_W'(BOOT_COUNT);
    localparam state_t           RST_STATE = AUTO_BOOT ? S_READ : S_IDLE;
    localparam logic [31:0]      RST_SRC   = AUTO_BOOT ? BOOT_SRC : 32'h0;
    localparam logic [31:0]      RST_DST   = AUTO_BOOT ? BOOT_DST : 32'h0;
    localparam logic [CNT_W-1:0] RST_COUNT = AUTO_BOOT ? BOOT_CNT : '0;

    // Address increment per transfer for a given access size.
    function automatic logic [31:0] stride(input logic [1:0] len);
        case (len)
            2'b00:   stride = 32'd1;
            2'b01:   stride = 32'd2;
            2'b10:   stride = 32'd4;
            default: stride = 32'd0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       len_q, len_d;
    logic [31:0]      hold_q, hold_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;

    logic             tick;
    logic             accept;
    logic [CNT_W-1:0] xfer_inc;

    assign tick     = (presc_q == DIV_V);
    // start is only honoured while no copy is in flight.
    assign accept   = start && (state_q != S_READ) && (state_q != S_WRITE);
    assign xfer_inc = xfer_q + 1'b1;

    // Prescaler: restarts on an accepted start so the first step of a new copy
    // always gets a full DIV+1 cycle window.
    always_comb begin
        if (accept || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        len_d   = len_q;
        hold_d  = hold_q;
        xfer_d  = xfer_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    src_d   = cfg_src;
                    dst_d   = cfg_dst;
                    count_d = cfg_count;
                    len_d   = cfg_len;
                    xfer_d  = '0;
                    if (cfg_len == 2'b11) begin
                        state_d = S_ERROR;
                    end else if (cfg_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (tick) begin
                    if (bus_exception) begin
                        state_d = S_ERROR;
                    end else begin
                        hold_d  = bus_rdata;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (tick) begin
                    // On a fault, src/dst/xfer stay at the faulting transfer.
                    if (bus_exception) begin
                        state_d = S_ERROR;
                    end else begin
                        src_d   = src_q + stride(len_q);
                        dst_d   = dst_q + stride(len_q);
                        xfer_d  = xfer_inc;
                        state_d = (xfer_inc == count_q) ? S_DONE : S_READ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            presc_q <= '0;
            src_q   <= RST_SRC;
            dst_q   <= RST_DST;
            count_q <= RST_COUNT;
            len_q   <= 2'b00;
            hold_q  <= '0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
            xfer_q  <= xfer_d;
        end
    end

    assign busy      = (state_q == S_READ) || (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign xfer_cnt  = xfer_q;
    assign bus_rw    = (state_q == S_WRITE);
    assign bus_len   = len_q;
    assign bus_addr  = (state_q == S_WRITE) ? dst_q : src_q;
    assign bus_wdata = hold_q;

endmodule

// File: tb/tb_boot_dma.sv
`timescale 1ns/1ps
module tb_boot_dma;

    localparam int          DIV        = 2;
    localparam int          D1         = DIV + 1;
    localparam int          CNT_W      = 16;
    localparam int          BOOT_COUNT = 5;
    localparam logic [31:0] BOOT_SRC   = 32'h1000_0000;
    localparam logic [31:0] BOOT_DST   = 32'h2000_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      cfg_src = '0;
    logic [31:0]      cfg_dst = '0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic [1:0]       cfg_len = '0;
    logic             busy, done, error;
    logic [CNT_W-1:0] xfer_cnt;
    logic             bus_rw;
    logic [1:0]       bus_len;
    logic [31:0]      bus_addr, bus_wdata, bus_rdata;
    logic             bus_exception;

    boot_dma #(
        .DIV(DIV), .DIV_W(20), .CNT_W(CNT_W), .AUTO_BOOT(1'b1),
        .BOOT_SRC(BOOT_SRC), .BOOT_DST(BOOT_DST), .BOOT_COUNT(BOOT_COUNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_count(cfg_count), .cfg_len(cfg_len),
        .busy(busy), .done(done), .error(error), .xfer_cnt(xfer_cnt),
        .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_exception(bus_exception)
    );

    always #5 clk = ~clk;

    // Bus-side memory (what the DUT really did) and reference memory (model).
    logic [7:0]  mem     [bit [31:0]];
    logic [7:0]  ref_mem [bit [31:0]];
    int          mem_ver = 0;
    int          wcyc = 0;
    bit          fault_on = 1'b0;
    logic [31:0] fault_addr = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    // data_bus: combinational read data, fault on one programmable address.
    always @(bus_addr or bus_len or mem_ver or rst_n) begin
        bus_rdata = '0;
        for (int b = 0; b < nbytes(bus_len); b++)
            bus_rdata[8*b +: 8] = mem_byte(bus_addr + 32'(b));
    end
    assign bus_exception = fault_on && (bus_addr == fault_addr);

    // Writes are applied every cycle the DUT drives a write; they are idempotent
    // because address and data are stable during a write step.
    always @(posedge clk) begin
        if (bus_rw) begin
            wcyc++;
            if (!bus_exception) begin
                for (int b = 0; b < nbytes(bus_len); b++)
                    mem[bus_addr + 32'(b)] = bus_wdata[8*b +: 8];
                mem_ver++;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int mem_diffs();
        int n = 0;
        foreach (ref_mem[a]) if (mem_byte(a) !== ref_mem[a]) n++;
        foreach (mem[a]) if (ref_byte(a) !== mem[a]) n++;
        return n;
    endfunction

    // Reference model: walks the access sequence r0,w0,r1,w1,... with plain
    // address arithmetic, updates ref_mem, and returns the expected outcome.
    // e_cyc counts clock edges from the start-accepting edge (inclusive) to the
    // edge after which done/error is visible.
    task automatic model(input logic [31:0] s, input logic [31:0] d, input int cnt,
                         input logic [1:0] len, output int e_cyc, output bit e_err,
                         output int e_x, output logic [31:0] e_addr, output int e_w);
        int          sz;
        logic [31:0] ra, wa;
        logic [7:0]  tmp [4];
        e_w = 0; e_x = 0; e_err = 1'b0; e_addr = s; e_cyc = 1;
        if (len == 2'b11) begin
            e_err = 1'b1;
            return;
        end
        if (cnt == 0) return;
        sz = nbytes(len);
        for (int i = 0; i < cnt; i++) begin
            ra = s + 32'(i * sz);
            wa = d + 32'(i * sz);
            e_x = i;
            e_addr = ra;
            if (fault_on && ra == fault_addr) begin
                e_err = 1'b1;
                e_cyc = 1 + (2*i + 1) * D1;
                return;
            end
            e_w += D1;
            if (fault_on && wa == fault_addr) begin
                e_err = 1'b1;
                e_cyc = 1 + (2*i + 2) * D1;
                return;
            end
            for (int b = 0; b < sz; b++) tmp[b] = ref_byte(ra + 32'(b));
            for (int b = 0; b < sz; b++) ref_mem[wa + 32'(b)] = tmp[b];
        end
        e_x = cnt;
        e_addr = s + 32'(cnt * sz);
        e_cyc = 1 + 2 * cnt * D1;
    endtask

    task automatic end_checks(input string tag, input bit ended, input int cyc, input int e_cyc,
                              input bit e_err, input int e_x, input logic [31:0] e_addr,
                              input int e_w, input int w0, input logic [1:0] len);
        check_val({tag, ":ended"}, 32'(ended), 32'd1);
        check_val({tag, ":cycles"}, cyc, e_cyc);
        check_val({tag, ":done"}, done, !e_err);
        check_val({tag, ":error"}, error, e_err);
        check_val({tag, ":busy"}, busy, 1'b0);
        check_val({tag, ":xfer_cnt"}, xfer_cnt, e_x);
        check_val({tag, ":bus_addr"}, bus_addr, e_addr);
        check_val({tag, ":bus_rw"}, bus_rw, 1'b0);
        check_val({tag, ":bus_len"}, bus_len, len);
        check_val({tag, ":write_cycles"}, wcyc - w0, e_w);
        check_val({tag, ":mem"}, mem_diffs(), 0);
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, ":sticky"}, {done, error}, {!e_err, e_err});
        ref_mem = mem;
    endtask

    task automatic run_xfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int cnt, input logic [1:0] len, input bit poke);
        int          e_cyc, e_x, e_w, w0, cyc;
        bit          e_err, ended;
        logic [31:0] e_addr;
        model(s, d, cnt, len, e_cyc, e_err, e_x, e_addr, e_w);
        @(negedge clk);
        cfg_src = s; cfg_dst = d; cfg_count = CNT_W'(cnt); cfg_len = len; start = 1'b1;
        w0 = wcyc;
        cyc = 0;
        ended = 1'b0;
        while (!ended && cyc < e_cyc + 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                cfg_src = $urandom; cfg_dst = $urandom;
                cfg_count = CNT_W'($urandom_range(1, 9)); cfg_len = 2'($urandom_range(0, 3));
                if (e_cyc > 1) begin
                    check_val({tag, ":launch_flags"}, {busy, done, error}, 3'b100);
                    check_val({tag, ":launch_xfer"}, xfer_cnt, 0);
                end
            end
            if (poke && e_cyc > 6 && cyc == 4) start = 1'b1;
            if (cyc == 5) start = 1'b0;
            if (done || error) ended = 1'b1;
        end
        start = 1'b0;
        end_checks(tag, ended, cyc, e_cyc, e_err, e_x, e_addr, e_w, w0, len);
    endtask

    // Expects rst_n low on entry: checks reset outputs, releases, checks boot copy.
    task automatic boot_check(input string tag);
        int          e_cyc, e_x, e_w, w0, cyc;
        bit          e_err, ended;
        logic [31:0] e_addr;
        check_val({tag, ":rst_flags"}, {busy, done, error}, 3'b100);
        check_val({tag, ":rst_xfer"}, xfer_cnt, 0);
        check_val({tag, ":rst_addr"}, bus_addr, BOOT_SRC);
        check_val({tag, ":rst_rw_len"}, {bus_rw, bus_len}, 3'b000);
        check_val({tag, ":rst_wdata"}, bus_wdata, 0);
        model(BOOT_SRC, BOOT_DST, BOOT_COUNT, 2'b00, e_cyc, e_err, e_x, e_addr, e_w);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wcyc;
        cyc = 0;
        ended = 1'b0;
        while (!ended && cyc < e_cyc + 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done || error) ended = 1'b1;
        end
        // Boot counts from reset release rather than from a start edge.
        end_checks(tag, ended, cyc, e_cyc - 1, e_err, e_x, e_addr, e_w, w0, 2'b00);
    endtask

    initial begin
        int          cnt, k, sz;
        logic [1:0]  len;
        logic [31:0] s, d;
        logic [7:0]  b8;

        for (int i = 0; i < BOOT_COUNT + 4; i++) begin
            b8 = 8'($urandom);
            mem[BOOT_SRC + 32'(i)] = b8;
            ref_mem[BOOT_SRC + 32'(i)] = b8;
        end
        #12;
        boot_check("boot");

        run_xfer("word", 32'h4000_0100, 32'h5000_0200, 2, 2'b10, 1'b0);
        run_xfer("half", 32'h4000_0181, 32'h5000_0281, 3, 2'b01, 1'b0);
        run_xfer("zero_count", 32'h4000_0000, 32'h5000_0000, 0, 2'b00, 1'b0);
        run_xfer("illegal_len", 32'h4000_0010, 32'h5000_0010, 5, 2'b11, 1'b0);
        fault_on = 1'b1; fault_addr = 32'h4000_0302;
        run_xfer("read_fault", 32'h4000_0300, 32'h5000_0300, 6, 2'b00, 1'b0);
        fault_on = 1'b0;
        run_xfer("after_err", 32'h4000_0400, 32'h5000_0400, 4, 2'b00, 1'b0);
        fault_on = 1'b1; fault_addr = 32'h5000_0508;
        run_xfer("write_fault", 32'h4000_0500, 32'h5000_0500, 4, 2'b10, 1'b0);
        fault_on = 1'b0;
        run_xfer("busy_poke", 32'h4000_0600, 32'h5000_0600, 6, 2'b00, 1'b1);
        run_xfer("wrap", 32'hFFFF_FFFD, 32'h5000_0700, 6, 2'b00, 1'b0);

        for (int t = 0; t < 30; t++) begin
            len = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            cnt = $urandom_range(0, 8);
            s = 32'h4000_0000 + 32'($urandom_range(0, 1023));
            d = 32'h6000_0000 + 32'($urandom_range(0, 1023));
            fault_on = (cnt > 0) && (len != 2'b11) && ($urandom_range(0, 3) == 0);
            if (fault_on) begin
                sz = nbytes(len);
                k = $urandom_range(0, 2*cnt - 1);
                fault_addr = ((k % 2) == 0 ? s : d) + 32'((k / 2) * sz);
            end
            run_xfer("random", s, d, cnt, len, 1'($urandom_range(0, 1)));
        end
        fault_on = 1'b0;

        // Abort a copy with an asynchronous reset, then expect a fresh boot copy
        // of changed flash contents.
        @(negedge clk);
        cfg_src = 32'h4000_0800; cfg_dst = 32'h5000_0800; cfg_count = 16'd10; cfg_len = 2'b00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        ref_mem = mem;
        for (int i = 0; i < BOOT_COUNT; i++) begin
            b8 = 8'($urandom);
            mem[BOOT_SRC + 32'(i)] = b8;
            ref_mem[BOOT_SRC + 32'(i)] = b8;
        end
        boot_check("reboot");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
